priority_arbiter: RTL and testbench

Fixed-priority, N-way request arbiter granting exactly one requester per cycle; index 0 has the highest priority. Provides a combinational "next grant" view (`pre_grt`/`pre_id`) and a registered, lock-held grant (`grt`/`id`) with an encoded winner index and valid flag. Sits between a set of masters (DMA channels, bus initiators) and a single shared resource.

---
 rtl/priority_arbiter.sv | 52 +++++
 tb/tb_priority_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - fixed-priority N-way arbiter with lock-held registered grant
// Build option: ARB_PREEMPT_EN makes higher-priority requests take the grant immediately.
module priority_arbiter #(
    parameter  int WIDTH = 32,
    localparam int BITW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grt,
    output logic [BITW:0]    id,
    output logic [WIDTH-1:0] pre_grt,
    output logic [BITW:0]    pre_id
);

    logic [WIDTH-1:0] lowest;
    logic             hold;
    logic [BITW-1:0]  pre_idx;

    // Two's-complement trick isolates the lowest set bit, i.e. the top-priority requester.
    assign lowest = req & (~req + WIDTH'(1));

`ifdef ARB_PREEMPT_EN
    assign hold = 1'b0;
`else
    assign hold = |(req & grt);
`endif

    assign pre_grt = hold ? grt : lowest;

    always_comb begin
        pre_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pre_grt[i]) begin
                pre_idx = BITW'(i);
            end
        end
    end

    assign pre_id = {|pre_grt, pre_idx};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grt <= '0;
            id  <= '0;
        end else begin
            grt <= pre_grt;
            id  <= pre_id;
        end
    end

endmodule

// File: tb/tb_priority_arbiter.sv
// tb/tb_priority_arbiter.sv - directed and random checks of priority_arbiter against an owner-index model
module tb_priority_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req = '0;
    logic [31:0] grt;
    logic [5:0]  id;
    logic [31:0] pre_grt;
    logic [5:0]  pre_id;

    int passed = 0;
    int total  = 0;
    int owner  = -1;

    priority_arbiter #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grt     (grt),
        .id      (id),
        .pre_grt (pre_grt),
        .pre_id  (pre_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Model state is just the index of the current owner (-1 = nobody).
    function automatic int model_next(input int cur, input logic [31:0] r);
`ifndef ARB_PREEMPT_EN
        if (cur >= 0 && r[cur]) return cur;
`endif
        for (int i = 0; i < 32; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] onehot_of(input int o);
        logic [31:0] v = '0;
        if (o >= 0) v[o] = 1'b1;
        return v;
    endfunction

    function automatic logic [5:0] id_of(input int o);
        return (o < 0) ? 6'd0 : {1'b1, 5'(o)};
    endfunction

    // Apply r, check the combinational view, clock once, check the registered grant.
    task automatic cycle(input logic [31:0] r, input bit full);
        int          nxt;
        int          prev;
        logic [31:0] pre_seen;
        req = r;
        #1;
        nxt = model_next(owner, r);
        pre_seen = pre_grt;
        if (full) begin
            chk("pre_grt", pre_grt, onehot_of(nxt));
            chk("pre_id", pre_id, id_of(nxt));
        end
        @(posedge clk);
        #1;
        prev  = owner;
        owner = nxt;
        chk("grt", grt, onehot_of(owner));
        chk("id", id, id_of(owner));
        if (full) begin
            chk("grt_onehot0", $onehot0(grt), 1);
            chk("grt_subset_req", grt & ~r, 0);
            chk("grt_eq_prev_pre", grt, pre_seen);
`ifndef ARB_PREEMPT_EN
            if (prev >= 0 && r[prev]) chk("owner_kept", grt[prev], 1);
`endif
        end
    endtask

    initial begin
        logic [31:0] r;
        // Reset with every requester active: grant held at zero, pre view is pure priority.
        req = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("rst_grt", grt, 0);
        chk("rst_id", id, 0);
        chk("rst_pre_grt", pre_grt, 32'h1);
        chk("rst_pre_id", pre_id, 6'h20);
        @(negedge clk);
        rst = 1'b0;
        owner = -1;
        cycle(32'hFFFF_FFFF, 1'b1);
        chk("first_grt", grt, 32'h1);
        chk("first_id", id, 6'h20);

        // Single requester for 32 cycles, then drop.
        cycle(32'h0, 1'b1);
        for (int k = 0; k < 32; k++) begin
            cycle(32'h0000_0100, 1'b0);
            chk("single_grt", grt, 32'h100);
            chk("single_id", id, 6'h28);
        end
        cycle(32'h0, 1'b1);
        chk("drop_grt", grt, 0);
        chk("drop_id", id, 0);

        // Lock vs higher priority.
        cycle(32'h20, 1'b1);
        chk("lock_own", grt, 32'h20);
        for (int k = 0; k < 3; k++) begin
            cycle(32'h24, 1'b1);
`ifdef ARB_PREEMPT_EN
            chk("preempt_grt", grt, 32'h4);
`else
            chk("lock_hold", grt, 32'h20);
`endif
        end
        cycle(32'h4, 1'b1);
        chk("handoff_grt", grt, 32'h4);
        chk("handoff_id", id, 6'h22);

        // Simultaneous idle requests.
        cycle(32'h0, 1'b1);
        req = 32'h8000_0012;
        #1;
        chk("simul_pre_grt", pre_grt, 32'h2);
        chk("simul_pre_id", pre_id, 6'h21);
        cycle(32'h8000_0012, 1'b1);
        chk("simul_grt", grt, 32'h2);
        chk("simul_id", id, 6'h21);

        // Asynchronous reset mid-grant.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_grt", grt, 0);
        chk("async_rst_id", id, 0);
        owner = -1;
        @(negedge clk);
        rst = 1'b0;

        // Random soak: each requester toggles occasionally so grants are held then released.
        r = $urandom;
        for (int k = 0; k < 300; k++) begin
            for (int b = 0; b < 32; b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 15) == 0) r = '0;
            cycle(r, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
